reindeer_mem_responder: RTL and testbench

- Memory-controller responder that services the core's instruction-fetch read port and a data load/store port, and drives a single-outstanding word-wide memory backend.
- Returns the fetch response strobe `mem_read_done` with the instruction word and its word address `mem_addr_ack`.
- Flags in-progress data traffic on `dram_rw_pending` so the fetch unit can hold off re-issuing after a redirect.
- Sits between the fetch/LSU blocks and the SRAM/DRAM backend wrapper.

---
 rtl/reindeer_mem_pkg.sv | 20 ++
 rtl/reindeer_req_slot.sv | 33 +++
 rtl/reindeer_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_reindeer_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reindeer_mem_pkg.sv
// Shared encodings and widths for the reindeer memory responder.
package reindeer_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } src_t;

    localparam int unsigned MEM_ADDR_BITS_DEF = 16;
    // Byte-to-word shift: the word address starts at this request bit.
    localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/reindeer_req_slot.sv
// One-entry request buffer: valid flag plus payload, with load/overwrite/clear.
module reindeer_req_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         overwrite,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic take_c;

    // A load landing on a full slot is only taken when overwrite is allowed
    // or the slot is being drained in the same cycle.
    assign take_c = load && (!valid || overwrite || clear);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (take_c) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reindeer_mem_responder.sv
// Fetch/LSU memory responder: two request slots, data-first arbiter, and a
// single-outstanding backend FSM.
module reindeer_mem_responder
    import reindeer_mem_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PC_BITWIDTH   = 32,
    parameter int unsigned MEM_ADDR_BITS = MEM_ADDR_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     read_mem_enable,
    input  logic [PC_BITWIDTH-1:0]   read_mem_addr,
    output logic                     mem_read_done,
    output logic [XLEN-1:0]          mem_data,
    output logic [MEM_ADDR_BITS-1:0] mem_addr_ack,
    output logic                     dram_rw_pending,
    input  logic                     data_req,
    input  logic                     data_we,
    input  logic [PC_BITWIDTH-1:0]   data_addr,
    input  logic [XLEN-1:0]          data_wdata,
    input  logic [XLEN/8-1:0]        data_be,
    output logic                     data_done,
    output logic [XLEN-1:0]          data_rdata,
    output logic                     be_req,
    output logic                     be_we,
    output logic [MEM_ADDR_BITS-1:0] be_addr,
    output logic [XLEN-1:0]          be_wdata,
    output logic [XLEN/8-1:0]        be_be,
    input  logic                     be_ready,
    input  logic                     be_rvalid,
    input  logic [XLEN-1:0]          be_rdata
);

    localparam int unsigned AW   = MEM_ADDR_BITS;
    localparam int unsigned BE_W = XLEN / 8;
    localparam int unsigned DW   = 1 + AW + XLEN + BE_W;
    localparam int unsigned AHI  = AW + WORD_LSB;

    state_t          state;
    src_t            cur_src;
    logic            f_valid;
    logic [AW-1:0]   f_addr;
    logic            d_valid;
    logic [DW-1:0]   d_payload;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [BE_W-1:0] d_be;
    logic            grant_data_c;
    logic            grant_fetch_c;
    logic            data_busy_c;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{read_mem_addr[WORD_LSB-1:0], read_mem_addr[PC_BITWIDTH-1:AHI],
                                data_addr[WORD_LSB-1:0], data_addr[PC_BITWIDTH-1:AHI]};

    assign {d_we, d_addr, d_wdata, d_be} = d_payload;

    assign grant_data_c  = (state == S_IDLE) && d_valid && !sync_reset;
    assign grant_fetch_c = (state == S_IDLE) && f_valid && !d_valid && !sync_reset;
    assign data_busy_c   = ((state == S_ISSUE) || (state == S_WAIT)) && (cur_src == SRC_DATA);

    reindeer_req_slot #(.W(AW)) u_fetch_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (read_mem_enable && !sync_reset),
        .overwrite (1'b1),
        .clear     (sync_reset || grant_fetch_c),
        .din       (read_mem_addr[AHI-1:WORD_LSB]),
        .valid     (f_valid),
        .dout      (f_addr)
    );

    reindeer_req_slot #(.W(DW)) u_data_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (data_req && !sync_reset),
        .overwrite (1'b0),
        .clear     (sync_reset || grant_data_c),
        .din       ({data_we, data_addr[AHI-1:WORD_LSB], data_wdata, data_be}),
        .valid     (d_valid),
        .dout      (d_payload)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            cur_src         <= SRC_FETCH;
            be_req          <= 1'b0;
            be_we           <= 1'b0;
            be_addr         <= '0;
            be_wdata        <= '0;
            be_be           <= '0;
            mem_read_done   <= 1'b0;
            mem_data        <= '0;
            mem_addr_ack    <= '0;
            data_done       <= 1'b0;
            data_rdata      <= '0;
            dram_rw_pending <= 1'b0;
        end else begin
            mem_read_done   <= 1'b0;
            data_done       <= 1'b0;
            dram_rw_pending <= d_valid || data_busy_c;
            if (sync_reset) begin
                // An accepted read must still be drained from the backend.
                be_req <= 1'b0;
                if ((state == S_WAIT) || (state == S_DRAIN)) begin
                    state <= be_rvalid ? S_IDLE : S_DRAIN;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (d_valid) begin
                            be_req   <= 1'b1;
                            be_we    <= d_we;
                            be_addr  <= d_addr;
                            be_wdata <= d_wdata;
                            be_be    <= d_be;
                            cur_src  <= SRC_DATA;
                            state    <= S_ISSUE;
                        end else if (f_valid) begin
                            be_req   <= 1'b1;
                            be_we    <= 1'b0;
                            be_addr  <= f_addr;
                            be_wdata <= '0;
                            be_be    <= '0;
                            cur_src  <= SRC_FETCH;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (be_ready) begin
                            be_req <= 1'b0;
                            if (be_we) begin
                                data_done <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (be_rvalid) begin
                            if (cur_src == SRC_DATA) begin
                                data_rdata <= be_rdata;
                                data_done  <= 1'b1;
                            end else begin
                                mem_data      <= be_rdata;
                                mem_addr_ack  <= be_addr;
                                mem_read_done <= 1'b1;
                            end
                            state <= S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        if (be_rvalid) begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // A second data request before data_done has no slot to land in.
    a_data_single_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        (data_req && !sync_reset) |-> !(d_valid || data_busy_c));

endmodule

// File: tb/tb_reindeer_mem_responder.sv
// Bench for reindeer_mem_responder: vector table plus multi-cycle sequences,
// with a backend model and an in-order completion scoreboard.
module tb_reindeer_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n, sync_reset;
    logic        read_mem_enable;
    logic [31:0] read_mem_addr;
    logic        mem_read_done;
    logic [31:0] mem_data;
    logic [15:0] mem_addr_ack;
    logic        dram_rw_pending;
    logic        data_req, data_we;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        be_req, be_we;
    logic [15:0] be_addr;
    logic [31:0] be_wdata;
    logic [3:0]  be_be;
    logic        be_ready, be_rvalid;
    logic [31:0] be_rdata;

    reindeer_mem_responder dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .read_mem_enable(read_mem_enable), .read_mem_addr(read_mem_addr),
        .mem_read_done(mem_read_done), .mem_data(mem_data), .mem_addr_ack(mem_addr_ack),
        .dram_rw_pending(dram_rw_pending),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be),
        .data_done(data_done), .data_rdata(data_rdata),
        .be_req(be_req), .be_we(be_we), .be_addr(be_addr), .be_wdata(be_wdata), .be_be(be_be),
        .be_ready(be_ready), .be_rvalid(be_rvalid), .be_rdata(be_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        int          rlat;
        logic [15:0] exp_word;
        int          exp_lat;
    } vec_t;

    exp_t        sb_q[$];
    logic [15:0] acc_q[$];
    int          n_checks = 0, n_pass = 0;
    int          done_cnt = 0, rvalid_cnt = 0;
    int          stall_cnt = 0, rlat_cfg = 0;
    logic        pend_rd = 1'b0, held = 1'b0;
    int          rd_cnt = 0;
    logic [15:0] rd_word, h_addr, wr_addr;
    logic [31:0] h_wdata, wr_data;
    logic [3:0]  h_be, wr_be;
    logic        h_we;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic is_data, input logic we, input logic [15:0] word,
                            input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.is_data = is_data; e.we = we; e.word = word; e.be = be;
        e.data = we ? wdata : mem_word(word);
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    endtask

    // Backend model: decides be_ready/be_rvalid for the next rising edge.
    initial begin
        be_ready = 1'b0; be_rvalid = 1'b0; be_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                be_ready = 1'b0; be_rvalid = 1'b0; pend_rd = 1'b0; held = 1'b0;
            end else begin
                be_rvalid = 1'b0;
                if (pend_rd) begin
                    if (rd_cnt == 0) begin
                        be_rvalid = 1'b1; be_rdata = mem_word(rd_word);
                        pend_rd = 1'b0; rvalid_cnt++;
                    end else rd_cnt--;
                end
                be_ready = 1'b0;
                if (be_req) begin
                    if (held)
                        chk("be_hold", {be_we, be_addr, be_wdata, be_be}, {h_we, h_addr, h_wdata, h_be});
                    else begin
                        held = 1'b1; h_we = be_we; h_addr = be_addr; h_wdata = be_wdata; h_be = be_be;
                    end
                    if (stall_cnt > 0) stall_cnt--;
                    else begin
                        be_ready = 1'b1; held = 1'b0;
                        acc_q.push_back(be_addr);
                        wr_addr = be_addr; wr_data = be_wdata; wr_be = be_be;
                        if (!be_we) begin pend_rd = 1'b1; rd_cnt = rlat_cfg; rd_word = be_addr; end
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on each done strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_read_done) begin
                done_cnt++;
                if (sb_q.size() == 0) chk("spurious_fetch_done", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("fetch_src", e.is_data, 0);
                    chk("fetch_ack", mem_addr_ack, e.word);
                    chk("fetch_data", mem_data, e.data);
                end
            end
            if (data_done) begin
                done_cnt++;
                if (sb_q.size() == 0) chk("spurious_data_done", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("data_src", e.is_data, 1);
                    if (e.we) begin
                        chk("st_addr", wr_addr, e.word);
                        chk("st_wdata", wr_data, e.data);
                        chk("st_be", wr_be, e.be);
                    end else chk("ld_data", data_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   c, dc0, rv0;
        logic [15:0] a0, a1;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 16'h0041, 3};
        vecs[1] = '{1'b0, 1'b0, 32'hFFFF_1238, 32'h0, 4'h0, 0, 0, 16'hC48E, 3};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0, 4'h0, 2, 1, 16'h0000, 6};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 0, 16'h0020, 3};
        vecs[4] = '{1'b1, 1'b1, 32'h0001_FFFC, 32'hDEAD_BEEF, 4'h5, 0, 0, 16'h7FFF, 2};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'h9, 4, 0, 16'h0010, 6};
        vecs[6] = '{1'b1, 1'b0, 32'h0003_0008, 32'h0, 4'h0, 1, 2, 16'hC002, 6};

        reset_n = 1'b0; sync_reset = 1'b0;
        read_mem_enable = 1'b0; read_mem_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {mem_read_done, data_done, be_req, be_we, dram_rw_pending}, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_ack_addr", {mem_addr_ack, be_addr}, 0);
        chk("rst_rdata", data_rdata, 0);
        chk("rst_wdata_be", {be_wdata, be_be}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            stall_cnt = vecs[i].stall; rlat_cfg = vecs[i].rlat;
            push_exp(vecs[i].is_data, vecs[i].we, vecs[i].exp_word, vecs[i].wdata, vecs[i].be);
            if (vecs[i].is_data) begin
                data_req = 1'b1; data_we = vecs[i].we; data_addr = vecs[i].addr;
                data_wdata = vecs[i].wdata; data_be = vecs[i].be;
            end else begin
                read_mem_enable = 1'b1; read_mem_addr = vecs[i].addr;
            end
            c = 0;
            forever begin
                @(negedge clk);
                read_mem_enable = 1'b0; data_req = 1'b0;
                if (mem_read_done || data_done || c > 40) break;
                c++;
            end
            chk($sformatf("lat[%0d]", i), c, vecs[i].exp_lat);
            @(negedge clk);
        end

        // Newest fetch wins while the slot is full; 0x200 must never issue.
        stall_cnt = 0; rlat_cfg = 0; acc_q.delete(); dc0 = done_cnt;
        push_exp(1'b0, 1'b0, 16'h0040, 32'h0, 4'h0);
        push_exp(1'b0, 1'b0, 16'h00C0, 32'h0, 4'h0);
        read_mem_enable = 1'b1; read_mem_addr = 32'h100; @(negedge clk);
        read_mem_addr = 32'h200; @(negedge clk);
        read_mem_addr = 32'h300; @(negedge clk);
        read_mem_enable = 1'b0;
        wait_done(dc0 + 2, 40);
        chk("ovw_done_count", done_cnt - dc0, 2);
        chk("ovw_issue_count", acc_q.size(), 2);
        a0 = (acc_q.size() > 0) ? acc_q[0] : 16'hFFFF;
        a1 = (acc_q.size() > 1) ? acc_q[1] : 16'hFFFF;
        chk("ovw_issue_order", {a0, a1}, {16'h0040, 16'h00C0});
        repeat (2) @(negedge clk);

        // Simultaneous load and fetch: data first, pending tracks the load.
        dc0 = done_cnt;
        push_exp(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
        push_exp(1'b0, 1'b0, 16'h0004, 32'h0, 4'h0);
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
        read_mem_enable = 1'b1; read_mem_addr = 32'h10;
        @(negedge clk);
        data_req = 1'b0; read_mem_enable = 1'b0;
        chk("col_pend_c0", dram_rw_pending, 0);
        @(negedge clk);
        chk("col_pend_c1", dram_rw_pending, 1);
        chk("col_first_issue", {be_req, be_addr}, {1'b1, 16'h0020});
        for (int i = 0; i < 20 && !data_done; i++) @(negedge clk);
        chk("col_data_done", data_done, 1);
        chk("col_pend_at_done", dram_rw_pending, 1);
        repeat (2) @(negedge clk);
        chk("col_pend_cleared", dram_rw_pending, 0);
        wait_done(dc0 + 2, 40);
        chk("col_done_count", done_cnt - dc0, 2);
        repeat (2) @(negedge clk);

        // sync_reset while waiting for read data: drain without a done strobe.
        rlat_cfg = 2; dc0 = done_cnt; rv0 = rvalid_cnt;
        read_mem_enable = 1'b1; read_mem_addr = 32'h500;
        @(negedge clk); read_mem_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain_in_wait", be_req, 0);
        sync_reset = 1'b1;
        @(negedge clk); sync_reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_no_done", done_cnt - dc0, 0);
        chk("drain_rvalid_seen", rvalid_cnt - rv0, 1);
        rlat_cfg = 0;
        push_exp(1'b0, 1'b0, 16'h0180, 32'h0, 4'h0);
        read_mem_enable = 1'b1; read_mem_addr = 32'h600;
        @(negedge clk); read_mem_enable = 1'b0;
        wait_done(dc0 + 1, 40);
        chk("post_drain_done", done_cnt - dc0, 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset while a request is stalled in issue.
        stall_cnt = 6; dc0 = done_cnt;
        read_mem_enable = 1'b1; read_mem_addr = 32'h700;
        @(negedge clk); read_mem_enable = 1'b0;
        @(negedge clk);
        chk("ar_issue", {be_req, be_addr}, {1'b1, 16'h01C0});
        #2 reset_n = 1'b0;
        #1;
        chk("ar_strobes", {be_req, mem_read_done, data_done, dram_rw_pending}, 0);
        chk("ar_be_addr", be_addr, 0);
        chk("ar_mem_data", mem_data, 0);
        chk("ar_ack", mem_addr_ack, 0);
        stall_cnt = 0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("ar_slots_empty", be_req, 0);
        chk("ar_no_done", done_cnt - dc0, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
